mold_seq_ctrl: RTL and testbench

//  Sequence controller downstream of the MoldUDP64 header/message decoder. Locks the session ID and tracks the expected sequence number.

---
 rtl/mold_seq_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_mold_seq_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mold_seq_ctrl.sv
// MoldUDP64 sequence controller.
// Locks the session ID on the first header, tracks the next expected
// sequence number, marks each message as keep/skip/drop and raises
// retransmission (gap) requests toward the replay logic.
//
// Gap port handshake: gap_v_o, gap_seq_o and gap_cnt_o are registered and
// stay stable while gap_v_o is high; the request retires on the cycle where
// gap_v_o & gap_ready_i are both high. A further gap detected while a request
// is still waiting extends that request (start kept, count grown, saturated).
//
// state_o is a debug view of the FSM: 0=IDLE, 1=WAIT, 2=PKT, 3=DONE.
module mold_seq_ctrl #(
  parameter int unsigned     SID_W   = 80,
  parameter int unsigned     SEQ_W   = 64,
  parameter int unsigned     ML_W    = 16,
  parameter logic [ML_W-1:0] GAP_MAX = 16'hFFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hdr_v_i,
  input  logic [SID_W-1:0] hdr_sid_i,
  input  logic [SEQ_W-1:0] hdr_seq_i,
  input  logic [ML_W-1:0]  hdr_cnt_i,
  input  logic             msg_end_i,
  input  logic             pkt_end_i,
  output logic             msg_keep_o,
  output logic             gap_v_o,
  output logic [SEQ_W-1:0] gap_seq_o,
  output logic [ML_W-1:0]  gap_cnt_o,
  input  logic             gap_ready_i,
  output logic [SEQ_W-1:0] exp_seq_o,
  output logic             sess_end_o,
  output logic [15:0]      sid_err_cnt_o,
  output logic [1:0]       state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_PKT  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Message count value that marks end of session.
  localparam logic [ML_W-1:0] CNT_END = '1;

  logic [1:0]       state_q, state_d;
  logic [SID_W-1:0] sid_q, sid_d;
  logic [SEQ_W-1:0] exp_q, exp_d;
  logic [ML_W-1:0]  skip_q, skip_d;
  logic [ML_W-1:0]  cnt_q, cnt_d;
  logic [ML_W-1:0]  idx_q, idx_d;
  logic             drop_q, drop_d;
  logic             sess_end_q, sess_end_d;
  logic [15:0]      sid_err_q, sid_err_d;
  logic             gap_v_q, gap_v_d;
  logic [SEQ_W-1:0] gap_seq_q, gap_seq_d;
  logic [ML_W-1:0]  gap_cnt_q, gap_cnt_d;

  // Header-derived helpers.
  logic             hdr_end;
  logic [ML_W-1:0]  hdr_msgs;
  logic [SEQ_W-1:0] seq_sum;
  logic [SEQ_W-1:0] dup_len;
  logic [SEQ_W-1:0] gap_len;
  logic [SEQ_W-1:0] merge_len;
  logic             proc_hdr;
  logic             new_gap;
  logic             gap_fire;

  // Clamp a SEQ_W-wide count to the gap request field.
  function automatic logic [ML_W-1:0] sat_cnt(input logic [SEQ_W-1:0] v);
    if (v > SEQ_W'(GAP_MAX)) sat_cnt = GAP_MAX;
    else                     sat_cnt = v[ML_W-1:0];
  endfunction

  // Next-state logic: FSM, sequence tracking, message index and gap request.
  always_comb begin
    state_d    = state_q;
    sid_d      = sid_q;
    exp_d      = exp_q;
    skip_d     = skip_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    drop_d     = drop_q;
    sess_end_d = sess_end_q;
    sid_err_d  = sid_err_q;
    gap_v_d    = gap_v_q;
    gap_seq_d  = gap_seq_q;
    gap_cnt_d  = gap_cnt_q;
    proc_hdr   = 1'b0;
    new_gap    = 1'b0;

    // An end-of-session packet carries no messages and does not advance exp.
    hdr_end   = (hdr_cnt_i == CNT_END);
    hdr_msgs  = hdr_end ? '0 : hdr_cnt_i;
    seq_sum   = hdr_seq_i + SEQ_W'(hdr_msgs);
    dup_len   = exp_q - hdr_seq_i;
    gap_len   = hdr_seq_i - exp_q;
    merge_len = hdr_seq_i - gap_seq_q;
    gap_fire  = gap_v_q & gap_ready_i;

    // Message index stops at the packet's count so trailing msg_end never wraps.
    if (msg_end_i && (idx_q < cnt_q)) idx_d = idx_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (hdr_v_i) begin
          sid_d      = hdr_sid_i;
          exp_d      = seq_sum;
          skip_d     = '0;
          drop_d     = 1'b0;
          cnt_d      = hdr_msgs;
          idx_d      = '0;
          sess_end_d = sess_end_q | hdr_end;
          state_d    = S_PKT;
        end
      end
      S_WAIT: begin
        if (hdr_v_i) proc_hdr = 1'b1;
      end
      S_PKT: begin
        // A header inside a packet implicitly ends the current packet.
        if (hdr_v_i) begin
          if (sess_end_q) state_d = S_DONE;
          else            proc_hdr = 1'b1;
        end else if (pkt_end_i) begin
          state_d = sess_end_q ? S_DONE : S_WAIT;
        end
      end
      default: ;
    endcase

    if (proc_hdr) begin
      state_d = S_PKT;
      idx_d   = '0;
      cnt_d   = hdr_msgs;
      skip_d  = '0;
      if (hdr_sid_i != sid_q) begin
        drop_d = 1'b1;
        if (sid_err_q != 16'hFFFF) sid_err_d = sid_err_q + 16'd1;
      end else begin
        drop_d     = 1'b0;
        sess_end_d = sess_end_q | hdr_end;
        if (hdr_seq_i > exp_q) begin
          new_gap = 1'b1;
          exp_d   = seq_sum;
        end else if (hdr_seq_i < exp_q) begin
          skip_d = (dup_len < SEQ_W'(hdr_msgs)) ? dup_len[ML_W-1:0] : hdr_msgs;
          exp_d  = (seq_sum > exp_q) ? seq_sum : exp_q;
        end else begin
          exp_d = seq_sum;
        end
      end
    end

    // A waiting request absorbs the new gap; otherwise a fresh one is loaded.
    if (new_gap) begin
      if (gap_v_q && !gap_ready_i) begin
        gap_cnt_d = sat_cnt(merge_len);
      end else begin
        gap_v_d   = 1'b1;
        gap_seq_d = exp_q;
        gap_cnt_d = sat_cnt(gap_len);
      end
    end else if (gap_fire) begin
      gap_v_d = 1'b0;
    end
  end

  // State registers; reset drops the session lock and any pending gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sid_q      <= '0;
      exp_q      <= '0;
      skip_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      drop_q     <= 1'b0;
      sess_end_q <= 1'b0;
      sid_err_q  <= '0;
      gap_v_q    <= 1'b0;
      gap_seq_q  <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sid_q      <= sid_d;
      exp_q      <= exp_d;
      skip_q     <= skip_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      drop_q     <= drop_d;
      sess_end_q <= sess_end_d;
      sid_err_q  <= sid_err_d;
      gap_v_q    <= gap_v_d;
      gap_seq_q  <= gap_seq_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign msg_keep_o    = (state_q == S_PKT) & ~drop_q & (idx_q >= skip_q) & (idx_q < cnt_q);
  assign gap_v_o       = gap_v_q;
  assign gap_seq_o     = gap_seq_q;
  assign gap_cnt_o     = gap_cnt_q;
  assign exp_seq_o     = exp_q;
  assign sess_end_o    = sess_end_q;
  assign sid_err_cnt_o = sid_err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_mold_seq_ctrl.sv
// Bench for mold_seq_ctrl: directed vector table, hand-written corner
// sequences and randomized packets against a sequence-set reference model.
module tb_mold_seq_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         hdr_v_i;
  logic [79:0]  hdr_sid_i;
  logic [63:0]  hdr_seq_i;
  logic [15:0]  hdr_cnt_i;
  logic         msg_end_i;
  logic         pkt_end_i;
  logic         msg_keep_o;
  logic         gap_v_o;
  logic [63:0]  gap_seq_o;
  logic [15:0]  gap_cnt_o;
  logic         gap_ready_i;
  logic [63:0]  exp_seq_o;
  logic         sess_end_o;
  logic [15:0]  sid_err_cnt_o;
  logic [1:0]   state_o;

  mold_seq_ctrl dut (
    .clk(clk), .reset(reset),
    .hdr_v_i(hdr_v_i), .hdr_sid_i(hdr_sid_i), .hdr_seq_i(hdr_seq_i), .hdr_cnt_i(hdr_cnt_i),
    .msg_end_i(msg_end_i), .pkt_end_i(pkt_end_i), .msg_keep_o(msg_keep_o),
    .gap_v_o(gap_v_o), .gap_seq_o(gap_seq_o), .gap_cnt_o(gap_cnt_o), .gap_ready_i(gap_ready_i),
    .exp_seq_o(exp_seq_o), .sess_end_o(sess_end_o), .sid_err_cnt_o(sid_err_cnt_o),
    .state_o(state_o)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  localparam logic [79:0] SID_A = 80'hA1A2_A3A4_A5A6_A7A8_A9AA;
  localparam logic [79:0] SID_B = 80'hB1B2_B3B4_B5B6_B7B8_B9BA;
  localparam logic [79:0] SID_C = 80'hC1C2_C3C4_C5C6_C7C8_C9CA;

  int n_tests = 0;
  int n_fail  = 0;
  bit rand_rdy = 1'b0;

  // Reference model: session lock, next expected number, the packet's first
  // number and the expected value at its header, and the missing interval.
  bit          m_locked, m_done, m_in_pkt, m_drop, m_sess_end, m_gv;
  logic [79:0] m_sid;
  logic [63:0] m_exp, m_pseq, m_hexp, m_gstart, m_gend;
  int          m_pcnt, m_idx, m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic m_reset();
    m_locked = 0; m_done = 0; m_in_pkt = 0; m_drop = 0; m_sess_end = 0; m_gv = 0;
    m_sid = '0; m_exp = '0; m_pseq = '0; m_hexp = '0; m_gstart = '0; m_gend = '0;
    m_pcnt = 0; m_idx = 0; m_err = 0;
  endtask

  // A message is new when its own sequence number is not below the
  // expected number seen at its packet's header.
  function automatic bit model_keep();
    logic [63:0] msg_seq;
    msg_seq = m_pseq + 64'(m_idx);
    return m_in_pkt && !m_drop && (m_idx < m_pcnt) && (msg_seq >= m_hexp);
  endfunction

  function automatic logic [15:0] model_gap_cnt();
    logic [63:0] n;
    n = m_gend - m_gstart + 64'd1;
    return (n > 64'hFFFF) ? 16'hFFFF : n[15:0];
  endfunction

  task automatic model_step();
    bit          consumed, ng;
    logic [63:0] ng_start, ng_end, top;
    int          msgs;
    consumed = m_gv && gap_ready_i;
    ng = 0; ng_start = '0; ng_end = '0;
    if (hdr_v_i && !m_done) begin
      if (m_in_pkt && m_sess_end) begin
        m_done = 1; m_in_pkt = 0;
      end else begin
        msgs = (hdr_cnt_i == 16'hFFFF) ? 0 : int'(hdr_cnt_i);
        m_in_pkt = 1; m_idx = 0; m_pcnt = msgs; m_pseq = hdr_seq_i;
        top = hdr_seq_i + 64'(msgs);
        if (!m_locked) begin
          m_locked = 1; m_sid = hdr_sid_i; m_drop = 0; m_hexp = hdr_seq_i; m_exp = top;
          if (hdr_cnt_i == 16'hFFFF) m_sess_end = 1;
        end else if (hdr_sid_i != m_sid) begin
          m_drop = 1;
          if (m_err < 65535) m_err++;
        end else begin
          m_drop = 0; m_hexp = m_exp;
          if (hdr_seq_i > m_exp) begin
            ng = 1; ng_start = m_exp; ng_end = hdr_seq_i - 64'd1;
          end
          if (top > m_exp) m_exp = top;
          if (hdr_cnt_i == 16'hFFFF) m_sess_end = 1;
        end
      end
    end else begin
      if (pkt_end_i && m_in_pkt) begin
        m_in_pkt = 0;
        if (m_sess_end) m_done = 1;
      end
      if (msg_end_i && m_idx < m_pcnt) m_idx++;
    end
    if (ng) begin
      if (m_gv && !consumed) m_gend = ng_end;
      else begin m_gv = 1; m_gstart = ng_start; m_gend = ng_end; end
    end else if (consumed) begin
      m_gv = 0;
    end
  endtask

  // One clock: check keep, advance the model, then check registered outputs.
  task automatic cycle();
    if (rand_rdy) gap_ready_i = 1'($urandom_range(0, 1));
    check("keep", msg_keep_o, model_keep());
    model_step();
    @(posedge clk); #1;
    check("exp_seq", exp_seq_o, m_exp);
    check("sess_end", sess_end_o, m_sess_end);
    check("sid_err", sid_err_cnt_o, 64'(m_err));
    check("gap_v", gap_v_o, m_gv);
    if (m_gv) begin
      check("gap_seq", gap_seq_o, m_gstart);
      check("gap_cnt", gap_cnt_o, model_gap_cnt());
    end
  endtask

  // Driver tasks
  task automatic do_hdr(input logic [79:0] sid, input logic [63:0] seq, input logic [15:0] cnt);
    hdr_v_i = 1; hdr_sid_i = sid; hdr_seq_i = seq; hdr_cnt_i = cnt;
    cycle();
    hdr_v_i = 0;
  endtask

  task automatic do_msg(output bit k);
    msg_end_i = 1;
    k = msg_keep_o;
    cycle();
    msg_end_i = 0;
  endtask

  task automatic do_end();
    pkt_end_i = 1;
    cycle();
    pkt_end_i = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic apply_reset();
    reset = 1;
    m_reset();
    #1;
    check("rst_keep", msg_keep_o, 0);
    check("rst_gap_v", gap_v_o, 0);
    check("rst_exp", exp_seq_o, 0);
    check("rst_sess_end", sess_end_o, 0);
    check("rst_err", sid_err_cnt_o, 0);
    check("rst_state", state_o, 0);
    @(posedge clk); #1;
    reset = 0;
  endtask

  typedef struct {
    logic [79:0] sid;
    logic [63:0] seq;
    logic [15:0] cnt;
    int          nmsg;
    bit          rdy;
    logic [7:0]  keep_mask;
    logic [63:0] x_exp;
    bit          x_gv;
    logic [63:0] x_gseq;
    logic [15:0] x_gcnt;
    logic [15:0] x_err;
  } vec_t;

  vec_t tbl[6];

  initial begin
    bit          k;
    int          r, cnt, nmsg;
    logic [63:0] seq, back;
    logic [79:0] sid;

    reset = 1; hdr_v_i = 0; hdr_sid_i = '0; hdr_seq_i = '0; hdr_cnt_i = '0;
    msg_end_i = 0; pkt_end_i = 0; gap_ready_i = 0;

    // lock, overlap, gap, merge, foreign session, messages beyond count
    tbl[0] = '{SID_A, 64'd1,  16'd3, 3, 1'b1, 8'b0000_0111, 64'd4,  1'b0, 64'd0, 16'd0,  16'd0};
    tbl[1] = '{SID_A, 64'd2,  16'd4, 4, 1'b1, 8'b0000_1100, 64'd6,  1'b0, 64'd0, 16'd0,  16'd0};
    tbl[2] = '{SID_A, 64'd10, 16'd1, 1, 1'b0, 8'b0000_0001, 64'd11, 1'b1, 64'd6, 16'd4,  16'd0};
    tbl[3] = '{SID_A, 64'd20, 16'd0, 0, 1'b0, 8'b0000_0000, 64'd20, 1'b1, 64'd6, 16'd14, 16'd0};
    tbl[4] = '{SID_B, 64'd30, 16'd2, 2, 1'b0, 8'b0000_0000, 64'd20, 1'b1, 64'd6, 16'd14, 16'd1};
    tbl[5] = '{SID_A, 64'd20, 16'd2, 4, 1'b0, 8'b0000_0011, 64'd22, 1'b1, 64'd6, 16'd14, 16'd1};

    apply_reset();

    for (int i = 0; i < 6; i++) begin
      gap_ready_i = tbl[i].rdy;
      do_hdr(tbl[i].sid, tbl[i].seq, tbl[i].cnt);
      check($sformatf("row%0d exp", i), exp_seq_o, tbl[i].x_exp);
      check($sformatf("row%0d gap_v", i), gap_v_o, tbl[i].x_gv);
      check($sformatf("row%0d err", i), sid_err_cnt_o, tbl[i].x_err);
      check($sformatf("row%0d state", i), state_o, 2);
      if (tbl[i].x_gv) begin
        check($sformatf("row%0d gap_seq", i), gap_seq_o, tbl[i].x_gseq);
        check($sformatf("row%0d gap_cnt", i), gap_cnt_o, tbl[i].x_gcnt);
      end
      for (int j = 0; j < tbl[i].nmsg; j++) begin
        do_msg(k);
        check($sformatf("row%0d keep%0d", i, j), k, tbl[i].keep_mask[j]);
      end
      do_end();
    end

    // Pending gap holds with stable fields until accepted.
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("hold gap_v", gap_v_o, 1);
      check("hold gap_seq", gap_seq_o, 6);
      check("hold gap_cnt", gap_cnt_o, 14);
    end
    gap_ready_i = 1;
    cycle();
    check("retire gap_v", gap_v_o, 0);

    // End of session, then headers are ignored.
    do_hdr(SID_A, 64'd22, 16'hFFFF);
    check("eos sess_end", sess_end_o, 1);
    check("eos exp", exp_seq_o, 22);
    do_end();
    check("done state", state_o, 3);
    do_hdr(SID_A, 64'd22, 16'd3);
    check("done exp", exp_seq_o, 22);
    do_msg(k);
    check("done keep", k, 0);
    do_hdr(SID_B, 64'd40, 16'd1);
    check("done err", sid_err_cnt_o, 1);

    // Async reset mid-packet with a gap pending.
    apply_reset();
    gap_ready_i = 0;
    do_hdr(SID_A, 64'd100, 16'd5);
    do_hdr(SID_A, 64'd110, 16'd2);
    check("pre_rst gap_seq", gap_seq_o, 105);
    check("pre_rst gap_cnt", gap_cnt_o, 5);
    do_msg(k);
    check("pre_rst keep", k, 1);
    #3 reset = 1;
    m_reset();
    #1;
    check("async keep", msg_keep_o, 0);
    check("async gap_v", gap_v_o, 0);
    check("async exp", exp_seq_o, 0);
    check("async state", state_o, 0);
    @(posedge clk); #1;
    reset = 0;
    do_hdr(SID_C, 64'd500, 16'd1);
    check("relock err", sid_err_cnt_o, 0);
    check("relock gap_v", gap_v_o, 0);
    check("relock exp", exp_seq_o, 501);
    do_end();

    // Gap count saturates.
    do_hdr(SID_C, 64'd70501, 16'd1);
    check("sat gap_seq", gap_seq_o, 501);
    check("sat gap_cnt", gap_cnt_o, 16'hFFFF);
    do_end();

    // Randomized packets, random ready.
    rand_rdy = 1;
    for (int p = 0; p < 250; p++) begin
      sid = ($urandom_range(0, 99) < 8) ? SID_B : SID_C;
      r = $urandom_range(0, 99);
      if (r < 3) seq = m_exp + 64'd70000 + 64'($urandom_range(0, 1000));
      else if (r < 40) begin
        back = 64'($urandom_range(0, 5));
        if (back > m_exp) back = m_exp;
        seq = m_exp - back;
      end else if (r < 70) seq = m_exp;
      else seq = m_exp + 64'($urandom_range(1, 8));
      cnt  = $urandom_range(0, 6);
      nmsg = $urandom_range(0, cnt + 2);
      do_hdr(sid, seq, 16'(cnt));
      for (int j = 0; j < nmsg; j++) begin
        do_msg(k);
        idle($urandom_range(0, 1));
      end
      if ($urandom_range(0, 99) < 80) do_end();
      idle($urandom_range(0, 2));
    end
    do_hdr(SID_C, m_exp + 64'd3, 16'hFFFF);
    do_end();
    do_hdr(SID_C, m_exp, 16'd2);
    do_msg(k);
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
